// File: rtl/decode_pkg.sv
// Shared decode definitions for the IF/ID stage, fetch and hazard logic.
//   - Opcode constants for the instructions decode treats specially
//   - JumpType encodings
//   - IF/ID latch record and its NOP value
//   - fp_src / dest_sel / imm_ext / jump_type helpers
package decode_pkg;

  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpFpu     = 6'h01;
  localparam logic [5:0] OpJ       = 6'h02;
  localparam logic [5:0] OpJal     = 6'h03;
  localparam logic [5:0] OpBeqz    = 6'h04;
  localparam logic [5:0] OpBnez    = 6'h05;
  localparam logic [5:0] OpBfpt    = 6'h06;
  localparam logic [5:0] OpBfpf    = 6'h07;
  localparam logic [5:0] OpAndi    = 6'h0c;
  localparam logic [5:0] OpOri     = 6'h0d;
  localparam logic [5:0] OpXori    = 6'h0e;
  localparam logic [5:0] OpLhi     = 6'h0f;
  localparam logic [5:0] OpJr      = 6'h12;
  localparam logic [5:0] OpJalr    = 6'h13;

  // FP-unit moves between register files address the GPR side at decode.
  localparam logic [5:0] FunctMovFp2I = 6'h34;
  localparam logic [5:0] FunctMovI2Fp = 6'h35;

  localparam logic [5:0] NopOp           = 6'h00;
  localparam logic [5:0] NopFunctDefault = 6'h15;

  typedef enum logic [1:0] {
    JtNone    = 2'b00,
    JtBranch  = 2'b01,
    JtJump    = 2'b10,
    JtJumpReg = 2'b11
  } jump_type_e;

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [31:0] pc_plus_four;
    logic        valid;
  } inst_t;

  function automatic inst_t nop_inst(logic [5:0] nop_funct);
    inst_t n;
    n       = '0;
    n.op    = NopOp;
    n.funct = nop_funct;
    return n;
  endfunction

  // Selects the FPR half of the register file for operand/destination addressing.
  function automatic logic fp_src(logic [5:0] op, logic [5:0] funct);
    return (op == OpFpu) && (funct != FunctMovFp2I) && (funct != FunctMovI2Fp);
  endfunction

  function automatic logic is_alu_imm(logic [5:0] op);
    logic r;
    case (op)
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
      6'h14, 6'h16, 6'h17, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h1c, 6'h1d: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_load(logic [5:0] op);
    logic r;
    case (op)
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Destination register {fp, index}; 0 means "no writeback".
  function automatic logic [5:0] dest_sel(logic [5:0] op, logic [5:0] funct, logic [4:0] rs2,
                                          logic [4:0] rd, logic [5:0] nop_funct,
                                          logic [4:0] link_reg);
    logic       fp;
    logic [5:0] d;
    fp = fp_src(op, funct);
    if (op == OpSpecial && funct == nop_funct) begin
      d = 6'd0;
    end else if (op == OpSpecial || op == OpFpu) begin
      d = {fp, rd};
    end else if (is_alu_imm(op) || is_load(op)) begin
      d = {fp, rs2};
    end else if (op == OpJal || op == OpJalr) begin
      d = {1'b0, link_reg};
    end else begin
      d = 6'd0;
    end
    return d;
  endfunction

  function automatic logic [31:0] imm_ext(logic [5:0] op, logic [4:0] rs1, logic [4:0] rs2,
                                          logic [15:0] imm);
    logic [31:0] r;
    case (op)
      OpAndi, OpOri, OpXori: r = {16'h0000, imm};
      OpLhi:                 r = {imm, 16'h0000};
      OpJ, OpJal:            r = {{6{rs1[4]}}, rs1, rs2, imm};
      default:               r = {{16{imm[15]}}, imm};
    endcase
    return r;
  endfunction

  function automatic jump_type_e jump_type(logic [5:0] op);
    jump_type_e r;
    case (op)
      OpBeqz, OpBnez, OpBfpt, OpBfpf: r = JtBranch;
      OpJ, OpJal:                     r = JtJump;
      OpJr, OpJalr:                   r = JtJumpReg;
      default:                        r = JtNone;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/regfile_64x32.sv
// 64 x 32 register file: entries 0-31 GPR, 32-63 FPR.
//   clk_i, rst_ni          clock, async active-low reset (clears every entry)
//   we_i, waddr_i, wdata_i write port; writes to entry 0 are dropped
//   raddr_a_i / rdata_a_o  async read port A
//   raddr_b_i / rdata_b_o  async read port B
// Entry 0 always reads 0. A write in flight to a read address is bypassed
// to that read port in the same cycle.
module regfile_64x32 (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_i,
  input  logic [5:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [5:0]  raddr_a_i,
  output logic [31:0] rdata_a_o,
  input  logic [5:0]  raddr_b_i,
  output logic [31:0] rdata_b_o
);

  logic [31:0] mem_q [64];
  logic        wr_en;

  assign wr_en = we_i && (waddr_i != 6'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 64; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_a_o = mem_q[raddr_a_i];
    if (raddr_a_i == 6'd0) begin
      rdata_a_o = '0;
    end else if (wr_en && waddr_i == raddr_a_i) begin
      rdata_a_o = wdata_i;
    end
  end

  always_comb begin
    rdata_b_o = mem_q[raddr_b_i];
    if (raddr_b_i == 6'd0) begin
      rdata_b_o = '0;
    end else if (wr_en && waddr_i == raddr_b_i) begin
      rdata_b_o = wdata_i;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// IF/ID pipeline latch plus instruction decode.
//   clk, reset (async, active low), stall (hold), flush (squash to NOP)
//   Fetch*        instruction fields from fetch
//   Wb*           writeback port, WbAddr = {fp, index}
//   Decode*       latched instruction, DecodeRd = {fp, dest}
//   Rs1Data/Rs2Data/ImmExt/JumpReg  operands
//   JumpType/BranchCond/CondSrc/BranchResult/Valid  control back to fetch
// Everything after the latch is combinational.
module decode_stage
  import decode_pkg::*;
#(
  parameter logic [5:0]  NopFunct = 6'h15,
  parameter int unsigned LinkReg  = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [5:0]  FetchOpCode,
  input  logic [5:0]  FetchFunction,
  input  logic [31:0] FetchPCPlusFour,
  input  logic [4:0]  FetchRs1,
  input  logic [4:0]  FetchRs2,
  input  logic [4:0]  FetchRd,
  input  logic [15:0] FetchImmediate,
  input  logic        WbEnable,
  input  logic [5:0]  WbAddr,
  input  logic [31:0] WbData,
  output logic [5:0]  DecodeOpCode,
  output logic [5:0]  DecodeFunction,
  output logic [5:0]  DecodeRd,
  output logic [31:0] DecodePCPlusFour,
  output logic [31:0] Rs1Data,
  output logic [31:0] Rs2Data,
  output logic [31:0] ImmExt,
  output logic [31:0] JumpReg,
  output logic [1:0]  JumpType,
  output logic        BranchCond,
  output logic        CondSrc,
  output logic        BranchResult,
  output logic        Valid
);

  localparam logic [4:0] LinkIdx = 5'(LinkReg);

  inst_t inst_d, inst_q;
  logic  fp;

  // Flush beats stall beats load.
  always_comb begin
    inst_d = inst_q;
    if (flush) begin
      inst_d = nop_inst(NopFunct);
    end else if (!stall) begin
      inst_d.op           = FetchOpCode;
      inst_d.funct        = FetchFunction;
      inst_d.rs1          = FetchRs1;
      inst_d.rs2          = FetchRs2;
      inst_d.rd           = FetchRd;
      inst_d.imm          = FetchImmediate;
      inst_d.pc_plus_four = FetchPCPlusFour;
      inst_d.valid        = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst_q <= nop_inst(NopFunct);
    end else begin
      inst_q <= inst_d;
    end
  end

  assign fp = fp_src(inst_q.op, inst_q.funct);

  regfile_64x32 u_regfile (
    .clk_i     (clk),
    .rst_ni    (reset),
    .we_i      (WbEnable),
    .waddr_i   (WbAddr),
    .wdata_i   (WbData),
    .raddr_a_i ({fp, inst_q.rs1}),
    .rdata_a_o (Rs1Data),
    .raddr_b_i ({fp, inst_q.rs2}),
    .rdata_b_o (Rs2Data)
  );

  always_comb begin
    DecodeOpCode     = inst_q.op;
    DecodeFunction   = inst_q.funct;
    DecodePCPlusFour = inst_q.pc_plus_four;
    Valid            = inst_q.valid;
    DecodeRd         = 6'd0;
    JumpType         = JtNone;
    if (inst_q.valid) begin
      DecodeRd = dest_sel(inst_q.op, inst_q.funct, inst_q.rs2, inst_q.rd, NopFunct, LinkIdx);
      JumpType = jump_type(inst_q.op);
    end
    ImmExt       = imm_ext(inst_q.op, inst_q.rs1, inst_q.rs2, inst_q.imm);
    BranchCond   = (inst_q.op == OpBeqz) || (inst_q.op == OpBfpt);
    CondSrc      = (inst_q.op == OpBfpt) || (inst_q.op == OpBfpf);
    BranchResult = (Rs1Data == 32'd0);
    JumpReg      = Rs1Data;
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes expected outputs, a
// negedge monitor pops and compares against the DUT.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [5:0]  FetchOpCode, FetchFunction;
  logic [31:0] FetchPCPlusFour;
  logic [4:0]  FetchRs1, FetchRs2, FetchRd;
  logic [15:0] FetchImmediate;
  logic        WbEnable;
  logic [5:0]  WbAddr;
  logic [31:0] WbData;
  logic [5:0]  DecodeOpCode, DecodeFunction, DecodeRd;
  logic [31:0] DecodePCPlusFour, Rs1Data, Rs2Data, ImmExt, JumpReg;
  logic [1:0]  JumpType;
  logic        BranchCond, CondSrc, BranchResult, Valid;

  always #5 clk = ~clk;

  decode_stage #(
    .NopFunct (6'h15),
    .LinkReg  (31)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .flush            (flush),
    .FetchOpCode      (FetchOpCode),
    .FetchFunction    (FetchFunction),
    .FetchPCPlusFour  (FetchPCPlusFour),
    .FetchRs1         (FetchRs1),
    .FetchRs2         (FetchRs2),
    .FetchRd          (FetchRd),
    .FetchImmediate   (FetchImmediate),
    .WbEnable         (WbEnable),
    .WbAddr           (WbAddr),
    .WbData           (WbData),
    .DecodeOpCode     (DecodeOpCode),
    .DecodeFunction   (DecodeFunction),
    .DecodeRd         (DecodeRd),
    .DecodePCPlusFour (DecodePCPlusFour),
    .Rs1Data          (Rs1Data),
    .Rs2Data          (Rs2Data),
    .ImmExt           (ImmExt),
    .JumpReg          (JumpReg),
    .JumpType         (JumpType),
    .BranchCond       (BranchCond),
    .CondSrc          (CondSrc),
    .BranchResult     (BranchResult),
    .Valid            (Valid)
  );

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [5:0]  rd;
    logic [31:0] pc4;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] jreg;
    logic [1:0]  jt;
    logic        bc;
    logic        cs;
    logic        br;
    logic        valid;
  } obs_t;

  typedef struct {
    string name;
    obs_t  v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  obs_t act;

  assign act = {DecodeOpCode, DecodeFunction, DecodeRd, DecodePCPlusFour, Rs1Data, Rs2Data,
                ImmExt, JumpReg, JumpType, BranchCond, CondSrc, BranchResult, Valid};

  function automatic obs_t mk(logic [5:0] op, logic [5:0] funct, logic [5:0] rd,
                              logic [31:0] pc4, logic [31:0] rs1, logic [31:0] rs2,
                              logic [31:0] imm, logic [1:0] jt, logic bc, logic cs, logic br,
                              logic valid);
    obs_t o;
    o.op = op; o.funct = funct; o.rd = rd; o.pc4 = pc4; o.rs1 = rs1; o.rs2 = rs2;
    o.imm = imm; o.jreg = rs1; o.jt = jt; o.bc = bc; o.cs = cs; o.br = br; o.valid = valid;
    return o;
  endfunction

  obs_t nop_exp;
  initial nop_exp = mk(6'h00, 6'h15, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0,
                       1'b1, 1'b0);

  task automatic expect_out(input string name, input obs_t v);
    exp_t e;
    e.name = name;
    e.v    = v;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.v);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fetch(input logic [5:0] op, input logic [5:0] funct, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [15:0] imm, input logic [31:0] pc4);
    FetchOpCode = op; FetchFunction = funct; FetchRs1 = rs1; FetchRs2 = rs2;
    FetchRd = rd; FetchImmediate = imm; FetchPCPlusFour = pc4;
  endtask

  task automatic wb(input logic en, input logic [5:0] addr, input logic [31:0] data);
    WbEnable = en; WbAddr = addr; WbData = data;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    drive_fetch(6'h04, 6'h00, 5'd5, 5'd7, 5'd0, 16'h1234, 32'h40);
    // Write during reset must be dropped; r12 is read back later.
    wb(1'b1, 6'd12, 32'hFFFF_FFFF);
    #1 expect_out("reset_nop", nop_exp);
    @(negedge clk);
    #2;
    reset = 1'b1;
    drive_fetch(6'h00, 6'h15, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0);
    wb(1'b1, 6'd5, 32'h0000_0000);
    step();
    wb(1'b1, 6'd7, 32'h1234_5678);
    step();
    wb(1'b1, 6'd0, 32'hDEAD_BEEF);
    step();
    wb(1'b1, 6'd32, 32'hDEAD_BEEF);
    step();
    wb(1'b1, 6'd6, 32'h8000_0001);
    step();
    wb(1'b0, 6'd0, 32'h0);

    drive_fetch(6'h04, 6'h00, 5'd5, 5'd7, 5'd17, 16'hFFF0, 32'h100);
    step();
    expect_out("beqz_zero", mk(6'h04, 6'h00, 6'd0, 32'h100, 32'd0, 32'h1234_5678, 32'hFFFF_FFF0,
                               2'b01, 1'b1, 1'b0, 1'b1, 1'b1));
    stall = 1'b1;
    drive_fetch(6'h03, 6'h00, 5'd31, 5'd31, 5'd3, 16'hFFFC, 32'h500);
    step();
    wb(1'b1, 6'd5, 32'd7);
    expect_out("beqz_bypass", mk(6'h04, 6'h00, 6'd0, 32'h100, 32'd7, 32'h1234_5678,
                                 32'hFFFF_FFF0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1));
    drive_fetch(6'h0d, 6'h00, 5'd7, 5'd4, 5'd1, 16'h8000, 32'h504);
    step();
    wb(1'b0, 6'd0, 32'h0);
    expect_out("stall_reread", mk(6'h04, 6'h00, 6'd0, 32'h100, 32'd7, 32'h1234_5678,
                                  32'hFFFF_FFF0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1));
    drive_fetch(6'h13, 6'h00, 5'd6, 5'd0, 5'd2, 16'h0001, 32'h508);
    step();
    expect_out("stall_hold", mk(6'h04, 6'h00, 6'd0, 32'h100, 32'd7, 32'h1234_5678,
                                32'hFFFF_FFF0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1));
    flush = 1'b1;
    step();
    expect_out("stall_flush", nop_exp);
    stall = 1'b0;
    flush = 1'b0;

    drive_fetch(6'h01, 6'h00, 5'd0, 5'd0, 5'd3, 16'h0, 32'h200);
    step();
    expect_out("fpr0_read", mk(6'h01, 6'h00, 6'h23, 32'h200, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd0,
                               2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
    drive_fetch(6'h00, 6'h20, 5'd0, 5'd7, 5'd9, 16'h0, 32'h204);
    step();
    expect_out("r0_read", mk(6'h00, 6'h20, 6'd9, 32'h204, 32'd0, 32'h1234_5678, 32'd0, 2'b00,
                             1'b0, 1'b0, 1'b1, 1'b1));
    drive_fetch(6'h03, 6'h00, 5'd31, 5'd31, 5'd3, 16'hFFFC, 32'h208);
    step();
    expect_out("jal", mk(6'h03, 6'h00, 6'd31, 32'h208, 32'd0, 32'd0, 32'hFFFF_FFFC, 2'b10,
                         1'b0, 1'b0, 1'b1, 1'b1));
    drive_fetch(6'h0d, 6'h00, 5'd7, 5'd4, 5'd17, 16'h8000, 32'h20c);
    step();
    expect_out("ori", mk(6'h0d, 6'h00, 6'd4, 32'h20c, 32'h1234_5678, 32'd0, 32'h0000_8000, 2'b00,
                         1'b0, 1'b0, 1'b0, 1'b1));
    drive_fetch(6'h0f, 6'h00, 5'd0, 5'd10, 5'd17, 16'hABCD, 32'h210);
    step();
    expect_out("lhi", mk(6'h0f, 6'h00, 6'd10, 32'h210, 32'd0, 32'd0, 32'hABCD_0000, 2'b00,
                         1'b0, 1'b0, 1'b1, 1'b1));
    drive_fetch(6'h13, 6'h00, 5'd6, 5'd0, 5'd17, 16'h0, 32'h214);
    step();
    expect_out("jalr", mk(6'h13, 6'h00, 6'd31, 32'h214, 32'h8000_0001, 32'd0, 32'd0, 2'b11,
                          1'b0, 1'b0, 1'b0, 1'b1));
    drive_fetch(6'h06, 6'h00, 5'd0, 5'd0, 5'd17, 16'h0004, 32'h218);
    step();
    expect_out("bfpt", mk(6'h06, 6'h00, 6'd0, 32'h218, 32'd0, 32'd0, 32'd4, 2'b01, 1'b1, 1'b1,
                          1'b1, 1'b1));
    drive_fetch(6'h05, 6'h00, 5'd7, 5'd0, 5'd17, 16'h7FFF, 32'h21c);
    step();
    expect_out("bnez", mk(6'h05, 6'h00, 6'd0, 32'h21c, 32'h1234_5678, 32'd0, 32'h0000_7FFF,
                          2'b01, 1'b0, 1'b0, 1'b0, 1'b1));
    drive_fetch(6'h08, 6'h00, 5'd6, 5'd12, 5'd17, 16'h8000, 32'h220);
    step();
    expect_out("addi", mk(6'h08, 6'h00, 6'd12, 32'h220, 32'h8000_0001, 32'd0, 32'hFFFF_8000,
                          2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
    flush = 1'b1;
    step();
    expect_out("flush", nop_exp);
    flush = 1'b0;

    drive_fetch(6'h12, 6'h00, 5'd7, 5'd0, 5'd17, 16'h0, 32'h224);
    step();
    expect_out("jr", mk(6'h12, 6'h00, 6'd0, 32'h224, 32'h1234_5678, 32'd0, 32'd0, 2'b11,
                        1'b0, 1'b0, 1'b0, 1'b1));
    drive_fetch(6'h00, 6'h20, 5'd7, 5'd6, 5'd9, 16'h0, 32'h228);
    step();
    #1 reset = 1'b0;
    expect_out("reset_mid", nop_exp);
    @(negedge clk);
    #2 reset = 1'b1;
    step();
    expect_out("after_reset", mk(6'h00, 6'h20, 6'd9, 32'h228, 32'd0, 32'd0, 32'd0, 2'b00,
                                 1'b0, 1'b0, 1'b1, 1'b1));
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter NopFunct, default 6'h15: Function code loaded on flush and reset (op 6'h00 + NopFunct = NOP).
REQ-002 Parameter LinkReg, default 31: GPR index written by JAL/JALR.
REQ-003 Port clk, in, 1: single clock; all state updates on rising edge.
REQ-004 Port reset, in, 1: asynchronous, active-low reset.
REQ-005 Port stall, in, 1: hold latched instruction.
REQ-006 Port flush, in, 1: squash latched instruction to NOP.
REQ-007 Ports FetchOpCode in 6, FetchFunction in 6, FetchPCPlusFour in 32, FetchRs1/FetchRs2/FetchRd in 5 each, FetchImmediate in 16: fetch-stage instruction fields.
REQ-008 Ports WbEnable in 1, WbAddr in 6, WbData in 32: writeback port; WbAddr is {fp, index}.
REQ-009 Ports DecodeOpCode out 6, DecodeFunction out 6, DecodeRd out 6, DecodePCPlusFour out 32: latched instruction; DecodeRd is {fp, dest}.
REQ-010 Ports Rs1Data out 32, Rs2Data out 32, ImmExt out 32, JumpReg out 32: operands.
REQ-011 Ports JumpType out 2, BranchCond out 1, CondSrc out 1, BranchResult out 1, Valid out 1: control to fetch.

Function
REQ-012 Latch priority each edge: flush > stall > load; flush loads op 00, NopFunct, all register fields 0, PCPlusFour 0, Valid 0; stall holds all fields; load captures fetch inputs, Valid 1.
REQ-013 Register file: 64x32, entries 0-31 GPR, 32-63 FPR; write on edge when WbEnable and WbAddr != 0; entry 0 reads 0 always.
REQ-014 Read addresses {fp_src(op,funct), Rs1} and {fp_src(op,funct), Rs2}, combinational from latched fields.
REQ-015 Bypass: WbEnable and WbAddr equal to nonzero read address -> read returns WbData in same cycle.
REQ-016 DecodeRd: op 00/01 -> {fp_src, Rd}; ALU-immediate, loads, LHI -> {fp_src, Rs2}; JAL (6'h03)/JALR (6'h13) -> {0, LinkReg}; stores, branches, J, JR, NOP, Valid 0 -> 0.
REQ-017 ImmExt: ANDI/ORI/XORI (0c/0d/0e) zero-extend 16; LHI (0f) -> {Imm,16'h0}; J/JAL sign-extend 26-bit {Rs1,Rs2,Imm}; all others sign-extend 16.
REQ-018 JumpType: 00 none; 01 BEQZ(04)/BNEZ(05)/BFPT(06)/BFPF(07); 10 J(02)/JAL(03); 11 JR(12)/JALR(13); forced 00 when Valid 0.
REQ-019 BranchCond 1 for BEQZ/BFPT, 0 otherwise; CondSrc 1 for BFPT/BFPF (FPSR), 0 otherwise (GPR).
REQ-020 BranchResult = (Rs1Data == 0), post-bypass; JumpReg = Rs1Data.
REQ-021 Stall with simultaneous writeback: write completes; held instruction re-reads new value next cycle.
REQ-022 All outputs besides latch registers purely combinational; zero added latency beyond the IF/ID edge.

Reset
REQ-023 reset low asynchronously sets latch to NOP state (REQ-012 flush values), Valid 0, all register entries 0.
REQ-024 Writes and loads ignored while reset low; first load on first rising edge after reset high.

Structure
REQ-025 Package decode_pkg holds opcode constants, JumpType encodings, NOP constants, fp_src and destination-select functions (shared with fetch/hazard logic).
REQ-026 One sub-module regfile_64x32: two async read ports, one write port, entry-0 zero, bypass.

Verification
REQ-027 Reset low mid-run -> DecodeOpCode 00, DecodeFunction 15, Valid 0, JumpType 00, Rs1Data 0 for any address.
REQ-028 Write GPR5=32'h0000_0000 then load BEQZ r5 -> JumpType 01, BranchCond 1, CondSrc 0, BranchResult 1; write GPR5=7 same cycle as decode -> BranchResult 0 (bypass).
REQ-029 Write WbAddr 0 data 32'hDEAD_BEEF then read r0 -> 0; write WbAddr 32 same data -> FPR0 reads 32'hDEAD_BEEF.
REQ-030 stall high 3 cycles with new fetch inputs -> outputs unchanged; stall and flush together -> NOP, Valid 0.
REQ-031 JAL with {Rs1,Rs2,Imm}=26'h3FF_FFFC -> ImmExt 32'hFFFF_FFFC, JumpType 10, DecodeRd 6'd31; ORI Imm 16'h8000 -> ImmExt 32'h0000_8000.
